// File: rtl/synchronous_register.sv
// synchronous_register: WIDTH-bit register with synchronous clear and clock enable
module synchronous_register #(
  parameter int          WIDTH       = 16,
  parameter logic [63:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             clk_ena,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] reg_out
);
  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("synchronous_register: WIDTH must be in 1..64");
  end
  if ((RESET_VALUE >> WIDTH) != 64'd0) begin : g_bad_reset
    $error("synchronous_register: RESET_VALUE does not fit in WIDTH bits");
  end
  // clear wins over load, load wins over hold
  always_comb reg_d = sclr ? RESET_VALUE[WIDTH-1:0] : clk_ena ? datain : reg_q;
  // single bank of flops; the output comes straight from them
  always_ff @(posedge clk) reg_q <= reg_d;
  assign reg_out = reg_q;
endmodule

// File: tb/tb_synchronous_register.sv
// tb_synchronous_register: directed self-checking bench for synchronous_register
module tb_synchronous_register;
  logic        clk = 1'b0;
  logic        sclr;
  logic        clk_ena;
  logic [15:0] datain;
  logic [15:0] reg_out;
  logic [15:0] model;
  logic        armed = 1'b0;
  int          checks = 0;
  int          errors = 0;

  synchronous_register #(.WIDTH(16), .RESET_VALUE(64'd0)) dut (
    .clk(clk),
    .sclr(sclr),
    .clk_ena(clk_ena),
    .datain(datain),
    .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic e, input logic [15:0] d);
    @(negedge clk);
    sclr = s;
    clk_ena = e;
    datain = d;
    @(posedge clk);
    #1;
  endtask

  // reference model of the expected register contents, checked every cycle
  always @(posedge clk) model <= sclr ? 16'h0000 : clk_ena ? datain : model;

  always @(negedge clk) if (armed) chk("model", reg_out, model);

  initial begin
    sclr = 1'b0;
    clk_ena = 1'b0;
    datain = 16'h0;
    step(1'b1, 1'b0, 16'hFFFF); chk("reset", reg_out, 16'h0000);
    armed = 1'b1;
    step(1'b0, 1'b1, 16'hAC53); chk("load", reg_out, 16'hAC53);
    step(1'b1, 1'b1, 16'hAC53); chk("sclr_over_ena", reg_out, 16'h0000);
    step(1'b0, 1'b1, 16'hAC53); chk("reload", reg_out, 16'hAC53);
    step(1'b0, 1'b0, 16'h1234); chk("hold1", reg_out, 16'hAC53);
    step(1'b0, 1'b0, 16'h1234); chk("hold2", reg_out, 16'hAC53);
    step(1'b0, 1'b1, 16'h1234); chk("load_after_hold", reg_out, 16'h1234);
    step(1'b1, 1'b0, 16'h5555); chk("reset_during_hold", reg_out, 16'h0000);
    step(1'b1, 1'b1, 16'h7777); chk("reset_held", reg_out, 16'h0000);
    step(1'b0, 1'b1, 16'h0001); chk("stream0", reg_out, 16'h0001);
    step(1'b0, 1'b1, 16'hFFFF); chk("stream1", reg_out, 16'hFFFF);
    step(1'b0, 1'b1, 16'h8000); chk("stream2", reg_out, 16'h8000);
    @(negedge clk);
    clk_ena = 1'b1;
    datain = 16'hA5A5;
    #1 chk("glitch_data", reg_out, 16'h8000);
    datain = 16'h5A5A;
    sclr = 1'b1;
    #1 chk("glitch_sclr", reg_out, 16'h8000);
    sclr = 1'b0;
    datain = 16'h1111;
    #1 chk("glitch_settle", reg_out, 16'h8000);
    @(posedge clk);
    #1 chk("glitch_edge", reg_out, 16'h1111);
    step(1'b0, 1'b0, 16'h2222);
    datain = 16'h3333;
    #1 chk("hold_toggle", reg_out, 16'h1111);
    clk_ena = 1'b1;
    #1 chk("ena_midcycle", reg_out, 16'h1111);
    @(posedge clk);
    #1 chk("ena_edge", reg_out, 16'h3333);
    step(1'b0, 1'b1, 16'hFFFF); chk("all_ones", reg_out, 16'hFFFF);
    step(1'b1, 1'b1, 16'hFFFF); chk("clear_all_bits", reg_out, 16'h0000);
    @(negedge clk);
    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
